// File: rtl/alarm_input_conditioner_pkg.sv
// Shared types and defaults for the alarm controller input front end.
package alarm_pkg;

    // Debounce FSM states. db is low in the first two states and high in the last two.
    typedef enum logic [1:0] {
        LOW_STABLE  = 2'b00,
        RISE_CHK    = 2'b01,
        HIGH_STABLE = 2'b10,
        FALL_CHK    = 2'b11
    } deb_state_t;

    localparam int DEB_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/alarm_input_conditioner_debounce_chan.sv
// One input channel: 2-flop synchronizer followed by a debounce FSM.
// A level change is accepted only after DEB_CYCLES consecutive synchronized
// samples at the new level; any bounce restarts the count from scratch.
// rise is a combinational strobe that is high in the cycle whose closing
// edge moves db from 0 to 1, so a register fed by it lines up with db.
import alarm_pkg::*;

module debounce_chan #(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam int              DEB_W    = $clog2(DEB_CYCLES) + 1;
    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] CNT_ONE  = DEB_W'(1);

    logic             s1;
    logic             s2;
    deb_state_t       state;
    logic [DEB_W-1:0] cnt;

    // Bring the asynchronous raw input into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce FSM: the counter tracks how many consecutive samples disagree with db.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOW_STABLE;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            case (state)
                LOW_STABLE: begin
                    if (s2) begin
                        state <= RISE_CHK;
                        cnt   <= CNT_ONE;
                    end
                end
                RISE_CHK: begin
                    if (!s2) begin
                        state <= LOW_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HIGH_STABLE;
                        db    <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HIGH_STABLE: begin
                    if (!s2) begin
                        state <= FALL_CHK;
                        cnt   <= CNT_ONE;
                    end
                end
                FALL_CHK: begin
                    if (s2) begin
                        state <= HIGH_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= LOW_STABLE;
                        db    <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= LOW_STABLE;
                    db    <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // High exactly when the next edge completes an accepted rising change.
    assign rise = (state == RISE_CHK) && s2 && (cnt == CNT_LAST);

endmodule

// File: rtl/alarm_input_conditioner.sv
// Alarm controller front end: conditions the raw remote-control and sensor
// inputs so the controller can consume everything on clk. cr becomes a
// one-cycle pulse per debounced press; sensors become debounced levels.
import alarm_pkg::*;

module alarm_input_conditioner #(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic cr,
    input  logic sm,
    input  logic sp,
    input  logic sj,
    output logic cr_pulse,
    output logic sm_db,
    output logic sp_db,
    output logic sj_db,
    output logic sensor_any
);

    logic cr_rise;
    logic unused_cr_db;
    logic unused_sm_rise;
    logic unused_sp_rise;
    logic unused_sj_rise;

    debounce_chan #(.DEB_CYCLES(DEB_CYCLES)) u_cr (
        .clk   (clk),
        .reset (reset),
        .raw   (cr),
        .db    (unused_cr_db),
        .rise  (cr_rise)
    );

    debounce_chan #(.DEB_CYCLES(DEB_CYCLES)) u_sm (
        .clk   (clk),
        .reset (reset),
        .raw   (sm),
        .db    (sm_db),
        .rise  (unused_sm_rise)
    );

    debounce_chan #(.DEB_CYCLES(DEB_CYCLES)) u_sp (
        .clk   (clk),
        .reset (reset),
        .raw   (sp),
        .db    (sp_db),
        .rise  (unused_sp_rise)
    );

    debounce_chan #(.DEB_CYCLES(DEB_CYCLES)) u_sj (
        .clk   (clk),
        .reset (reset),
        .raw   (sj),
        .db    (sj_db),
        .rise  (unused_sj_rise)
    );

    // Register the cr rising strobe so the pulse lands on the same edge cr db goes high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cr_pulse <= 1'b0;
        end else begin
            cr_pulse <= cr_rise;
        end
    end

    assign sensor_any = sm_db | sp_db | sj_db;

endmodule

// File: tb/tb_alarm_input_conditioner.sv
// Bench for alarm_input_conditioner: directed scenarios plus randomized input
// traffic, all outputs compared every cycle against a run-length reference model.
module tb_alarm_input_conditioner;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset;
    logic cr, sm, sp, sj;
    logic cr_pulse, sm_db, sp_db, sj_db, sensor_any;

    int checks = 0;
    int errors = 0;

    alarm_input_conditioner #(.DEB_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset      (reset),
        .cr         (cr),
        .sm         (sm),
        .sp         (sp),
        .sj         (sj),
        .cr_pulse   (cr_pulse),
        .sm_db      (sm_db),
        .sp_db      (sp_db),
        .sj_db      (sj_db),
        .sensor_any (sensor_any)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    // ---------------- checking task ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw samples travel through a two-deep queue (the synchronizer delay).
    // Each channel keeps a run length of consecutive samples that disagree
    // with its debounced level; reaching DEB flips the level.
    logic [3:0] pipe_q[$] = '{4'b0000, 4'b0000};
    logic [3:0] m_db = 4'b0000;
    int         m_run[4] = '{0, 0, 0, 0};
    logic       m_pulse = 1'b0;

    always @(posedge clk or posedge reset) begin : model_blk
        logic [3:0] seen;
        if (reset) begin
            pipe_q  = '{4'b0000, 4'b0000};
            m_db    = 4'b0000;
            m_run   = '{0, 0, 0, 0};
            m_pulse = 1'b0;
        end else begin
            seen = pipe_q.pop_front();
            pipe_q.push_back({sj, sp, sm, cr});
            m_pulse = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (seen[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_db[i]  = ~m_db[i];
                        m_run[i] = 0;
                        if (i == 0 && m_db[0]) m_pulse = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int   pulse_cnt = 0;
    int   last_pulse_edge = 0;
    int   prev_pulse_edge = 0;
    logic sp_seen = 1'b0;
    logic any_seen = 1'b0;

    always @(negedge clk) begin
        check_eq("cr_pulse", {31'd0, cr_pulse}, {31'd0, m_pulse});
        check_eq("sm_db", {31'd0, sm_db}, {31'd0, m_db[1]});
        check_eq("sp_db", {31'd0, sp_db}, {31'd0, m_db[2]});
        check_eq("sj_db", {31'd0, sj_db}, {31'd0, m_db[3]});
        check_eq("sensor_any", {31'd0, sensor_any}, {31'd0, |m_db[3:1]});
        if (cr_pulse) begin
            pulse_cnt++;
            prev_pulse_edge = last_pulse_edge;
            last_pulse_edge = edge_n;
        end
        if (sp_db) sp_seen = 1'b1;
        if (sensor_any) any_seen = 1'b1;
    end

    // ---------------- driver ----------------
    // Called at a negedge: apply v, then hold it for n sampling edges.
    task automatic drive(input logic [3:0] v, input int n);
        {sj, sp, sm, cr} = v;
        repeat (n) @(negedge clk);
    endtask

    int e;
    int p0;
    logic [3:0] rv;

    initial begin
        reset = 1'b1;
        {sj, sp, sm, cr} = 4'b0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_cr_pulse", {31'd0, cr_pulse}, 32'd0);
        check_eq("rst_sensor_any", {31'd0, sensor_any}, 32'd0);
        drive(4'b0000, 5);

        // Clean press: one pulse DEB+1 edges after first sample, none on release.
        p0 = pulse_cnt;
        e  = edge_n + 1;
        drive(4'b0001, 20);
        check_eq("clean_cnt", pulse_cnt, p0 + 1);
        check_eq("clean_edge", last_pulse_edge, e + DEB + 1);
        drive(4'b0000, 15);
        check_eq("release_nopulse", pulse_cnt, p0 + 1);

        // Bounce: short high/low pairs, then a stable high.
        p0 = pulse_cnt;
        drive(4'b0001, 2);
        drive(4'b0000, 2);
        drive(4'b0001, 2);
        drive(4'b0000, 2);
        check_eq("bounce_none", pulse_cnt, p0);
        e = edge_n + 1;
        drive(4'b0001, 12);
        check_eq("bounce_cnt", pulse_cnt, p0 + 1);
        check_eq("bounce_edge", last_pulse_edge, e + DEB + 1);
        drive(4'b0000, 12);

        // Glitch on sp shorter than the debounce window.
        sp_seen  = 1'b0;
        any_seen = 1'b0;
        drive(4'b0100, 3);
        drive(4'b0000, 12);
        check_eq("glitch_sp_db", {31'd0, sp_seen}, 32'd0);
        check_eq("glitch_any", {31'd0, any_seen}, 32'd0);

        // Simultaneous rise of sm and sj, then sm falls alone.
        drive(4'b1010, 5);
        check_eq("simul_sm_early", {31'd0, sm_db}, 32'd0);
        drive(4'b1010, 1);
        check_eq("simul_sm_db", {31'd0, sm_db}, 32'd1);
        check_eq("simul_sj_db", {31'd0, sj_db}, 32'd1);
        check_eq("simul_any", {31'd0, sensor_any}, 32'd1);
        drive(4'b1000, 10);
        check_eq("simul_sm_fall", {31'd0, sm_db}, 32'd0);
        check_eq("simul_any_hold", {31'd0, sensor_any}, 32'd1);
        drive(4'b0000, 10);
        check_eq("simul_any_clear", {31'd0, sensor_any}, 32'd0);

        // Rapid presses: 4 high, 4 low, 4 high -> two pulses 2*DEB apart.
        p0 = pulse_cnt;
        drive(4'b0001, 4);
        drive(4'b0000, 4);
        drive(4'b0001, 4);
        drive(4'b0000, 12);
        check_eq("rapid_cnt", pulse_cnt, p0 + 2);
        check_eq("rapid_gap", last_pulse_edge - prev_pulse_edge, 2 * DEB);

        // Reset mid-cycle with every input held high.
        drive(4'b1111, 12);
        check_eq("pre_rst_any", {31'd0, sensor_any}, 32'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_eq("async_cr_pulse", {31'd0, cr_pulse}, 32'd0);
        check_eq("async_sm_db", {31'd0, sm_db}, 32'd0);
        check_eq("async_sp_db", {31'd0, sp_db}, 32'd0);
        check_eq("async_sj_db", {31'd0, sj_db}, 32'd0);
        check_eq("async_any", {31'd0, sensor_any}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        p0 = pulse_cnt;
        e  = edge_n + 1;
        drive(4'b1111, 12);
        check_eq("post_rst_cnt", pulse_cnt, p0 + 1);
        check_eq("post_rst_edge", last_pulse_edge, e + DEB + 1);
        check_eq("post_rst_sj", {31'd0, sj_db}, 32'd1);
        drive(4'b0000, 12);

        // Randomized traffic with occasional asynchronous resets.
        rv = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            rv = rv ^ 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #1 reset = 1'b0;
                @(negedge clk);
            end
            drive(rv, $urandom_range(1, 10));
        end
        drive(4'b0000, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
